ex_mem_skid: RTL and testbench
==============================

EX_MEM_SKID -- requirements
Module: ex_mem_skid

Interface
REQ-001 Parameter DATA_W, default 16: width of the data1 and aluResult payload fields.
REQ-002 Parameter REG_ADDR_W, default 3: width of the destination-register field.
REQ-003 clk_i  in  1: single clock; all state updates on its rising edge.
REQ-004 rst_i  in  1: reset, synchronous, active-high.
REQ-005 flush_i  in  1: discard all held entries (branch/exception kill).
REQ-006 ex_valid_i  in  1: EX stage presents a valid instruction.
REQ-007 ex_ready_o  out  1: block accepts an EX instruction this cycle.
REQ-008 ex_data1_i  in  DATA_W: store data.
REQ-009 ex_aluResult_i  in  DATA_W: ALU result / memory address.
REQ-010 ex_reg3_i  in  REG_ADDR_W: destination register.
REQ-011 ex_resultOrMem_i, ex_memRead_i, ex_memWrite_i, ex_regWrite_i  in  1 each: control bits.
REQ-012 mem_valid_o  out  1: MEM-side entry valid.
REQ-013 mem_ready_i  in  1: MEM stage consumes the entry this cycle.
REQ-014 mem_data1_o, mem_aluResult_o  out  DATA_W; mem_reg3_o  out  REG_ADDR_W: payload.
REQ-015 mem_resultOrMem_o, mem_memRead_o, mem_memWrite_o, mem_regWrite_o  out  1 each: control.
REQ-016 occ_o  out  2: number of held entries (0..2).

Function
REQ-017 in_fire = ex_valid_i & ex_ready_o; out_fire = mem_valid_o & mem_ready_i.
REQ-018 Two registers: main (M, drives outputs) and skid (S); states EMPTY, ONE (M valid), TWO (M and S valid).
REQ-019 ex_ready_o = not S-valid, driven directly from a flop, with no combinational path from mem_ready_i.
REQ-020 EMPTY: on in_fire, load M and go to ONE; otherwise stay in EMPTY.
REQ-021 ONE: in_fire & out_fire, load M and stay in ONE; in_fire only, load S and go to TWO; out_fire only, go to EMPTY.
REQ-022 TWO: ex_ready_o = 0; on out_fire, copy S into M and go to ONE.
REQ-023 Latency: an entry accepted in cycle N is visible on mem_* in cycle N+1 when the block was in EMPTY or drained in cycle N.
REQ-024 Throughput: one entry per cycle sustained while mem_ready_i = 1.
REQ-025 While mem_valid_o = 1 and mem_ready_i = 0, all mem_* outputs and mem_valid_o hold stable.
REQ-026 mem_memRead_o, mem_memWrite_o and mem_regWrite_o are ANDed with mem_valid_o, so they are 0 when no entry is valid.
REQ-027 Data fields hold their last value when invalid.
REQ-028 Order is preserved: entries leave in acceptance order, with no loss or duplication.
REQ-029 flush_i = 1: next state EMPTY, both valids cleared, and any same-cycle in_fire discarded; ex_ready_o = 1 the following cycle.
REQ-030 flush_i has priority over in_fire and out_fire; rst_i has priority over flush_i.
REQ-031 occ_o = 0, 1 or 2 in EMPTY, ONE or TWO respectively.

Reset
REQ-032 On a rising edge with rst_i = 1, the block enters EMPTY and every mem_* output becomes 0.
REQ-033 On the same edge, mem_valid_o = 0, occ_o = 0, ex_ready_o = 1 and S is cleared.
REQ-034 Inputs are ignored while rst_i = 1.
REQ-035 Reset mid-operation drops all held entries with no output pulse.

Configuration
REQ-036 Macro EX_MEM_SKID_SKIDBUF_EN defined: the skid register and the TWO state exist as in REQ-018..REQ-022.
REQ-037 Macro undefined: single register with no S and no TWO state; occ_o is at most 1.
REQ-038 Macro undefined: ex_ready_o = (not M-valid) | mem_ready_i, combinational.
REQ-039 Macro undefined: all other requirements apply unchanged.

Verification
REQ-040 Reset: rst_i = 1 for 2 cycles with random inputs -> mem_valid_o = 0, all mem_* = 0, occ_o = 0, ex_ready_o = 1.
REQ-041 Streaming: 8 back-to-back entries with aluResult 0x0001..0x0008 and mem_ready_i = 1 -> mem_valid_o high 8 consecutive cycles starting one cycle after the first accept, values 0x0001..0x0008 in order.
REQ-042 Backpressure (macro on): ready dropped after entry 0x0010 is accepted, while 0x0011 and 0x0012 are offered -> 0x0011 is skidded, occ_o = 2, ex_ready_o = 0, 0x0012 is held off, outputs stay stable. On ready release the order is 0x0010, 0x0011, 0x0012.
REQ-043 Flush: occ_o = 2, then flush_i = 1 with ex_valid_i = 1 carrying 0x00AA -> next cycle mem_valid_o = 0, occ_o = 0, and 0x00AA never appears.
REQ-044 Control gating: entry with memWrite = 1, regWrite = 1, then drain -> mem_memWrite_o and mem_regWrite_o go 0 the cycle mem_valid_o falls.
REQ-045 Macro off, DATA_W = 32, REG_ADDR_W = 5: with M full and mem_ready_i = 1, ex_valid_i = 1 -> ex_ready_o = 1 the same cycle, 32-bit 0xDEADBEEF and reg3 = 31 pass through intact.

Source files
------------

// File: rtl/ex_mem_skid.sv
// EX->MEM pipeline register with valid/ready flow control and flush.
// Define EX_MEM_SKIDBUF_EN... namely EX_MEM_SKID_SKIDBUF_EN to add a skid entry (registered ex_ready_o).
module ex_mem_skid #(
  parameter int DATA_W     = 16,
  parameter int REG_ADDR_W = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  ex_valid_i,
  output logic                  ex_ready_o,
  input  logic [DATA_W-1:0]     ex_data1_i,
  input  logic [DATA_W-1:0]     ex_aluResult_i,
  input  logic [REG_ADDR_W-1:0] ex_reg3_i,
  input  logic                  ex_resultOrMem_i,
  input  logic                  ex_memRead_i,
  input  logic                  ex_memWrite_i,
  input  logic                  ex_regWrite_i,
  output logic                  mem_valid_o,
  input  logic                  mem_ready_i,
  output logic [DATA_W-1:0]     mem_data1_o,
  output logic [DATA_W-1:0]     mem_aluResult_o,
  output logic [REG_ADDR_W-1:0] mem_reg3_o,
  output logic                  mem_resultOrMem_o,
  output logic                  mem_memRead_o,
  output logic                  mem_memWrite_o,
  output logic                  mem_regWrite_o,
  output logic [1:0]            occ_o
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
  // valid never depends on ready, and a presented entry holds until it transfers.

  typedef struct packed {
    logic [DATA_W-1:0]     data1;
    logic [DATA_W-1:0]     alu;
    logic [REG_ADDR_W-1:0] reg3;
    logic                  result_or_mem;
    logic                  mem_read;
    logic                  mem_write;
    logic                  reg_write;
  } entry_t;

  // State encoding equals occupancy, so occ_o doubles as the FSM debug view.
`ifdef EX_MEM_SKID_SKIDBUF_EN
  typedef enum logic [1:0] {ST_EMPTY = 2'd0, ST_ONE = 2'd1, ST_TWO = 2'd2} state_t;
`else
  typedef enum logic [1:0] {ST_EMPTY = 2'd0, ST_ONE = 2'd1} state_t;
`endif

  state_t r_state;
  state_t w_state_nxt;
  entry_t r_m;
  entry_t w_in;
  logic   w_m_valid;
  logic   w_in_fire;
  logic   w_out_fire;
  logic   w_load_m;

  assign w_in = '{data1: ex_data1_i, alu: ex_aluResult_i, reg3: ex_reg3_i,
                  result_or_mem: ex_resultOrMem_i, mem_read: ex_memRead_i,
                  mem_write: ex_memWrite_i, reg_write: ex_regWrite_i};

  assign w_m_valid  = (r_state != ST_EMPTY);
  assign w_in_fire  = ex_valid_i & ex_ready_o;
  assign w_out_fire = w_m_valid & mem_ready_i;

`ifdef EX_MEM_SKID_SKIDBUF_EN
  entry_t r_s;
  logic   r_ex_ready;
  logic   w_load_s;
  logic   w_m_from_s;

  assign ex_ready_o = r_ex_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_load_m    = 1'b0;
    w_load_s    = 1'b0;
    w_m_from_s  = 1'b0;
    if (flush_i) begin
      w_state_nxt = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_in_fire) begin
            w_load_m    = 1'b1;
            w_state_nxt = ST_ONE;
          end
        end
        ST_ONE: begin
          if (w_in_fire && w_out_fire) begin
            w_load_m = 1'b1;
          end else if (w_in_fire) begin
            w_load_s    = 1'b1;
            w_state_nxt = ST_TWO;
          end else if (w_out_fire) begin
            w_state_nxt = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (w_out_fire) begin
            w_m_from_s  = 1'b1;
            w_state_nxt = ST_ONE;
          end
        end
        default: w_state_nxt = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= ST_EMPTY;
      r_ex_ready <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_ex_ready <= (w_state_nxt != ST_TWO);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_m <= '0;
      r_s <= '0;
    end else begin
      if (w_load_m) begin
        r_m <= w_in;
      end else if (w_m_from_s) begin
        r_m <= r_s;
      end
      if (w_load_s) begin
        r_s <= w_in;
      end
    end
  end
`else
  // Without the skid entry, ready must see mem_ready_i to keep full throughput.
  assign ex_ready_o = ~w_m_valid | mem_ready_i;

  always_comb begin
    w_state_nxt = r_state;
    w_load_m    = 1'b0;
    if (flush_i) begin
      w_state_nxt = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_in_fire) begin
            w_load_m    = 1'b1;
            w_state_nxt = ST_ONE;
          end
        end
        ST_ONE: begin
          if (w_in_fire) begin
            w_load_m = 1'b1;
          end else if (w_out_fire) begin
            w_state_nxt = ST_EMPTY;
          end
        end
        default: w_state_nxt = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_m <= '0;
    end else if (w_load_m) begin
      r_m <= w_in;
    end
  end
`endif

  assign mem_valid_o       = w_m_valid;
  assign mem_data1_o       = r_m.data1;
  assign mem_aluResult_o   = r_m.alu;
  assign mem_reg3_o        = r_m.reg3;
  assign mem_resultOrMem_o = r_m.result_or_mem;
  assign mem_memRead_o     = r_m.mem_read  & w_m_valid;
  assign mem_memWrite_o    = r_m.mem_write & w_m_valid;
  assign mem_regWrite_o    = r_m.reg_write & w_m_valid;
  assign occ_o             = r_state;

endmodule

// File: tb/tb_ex_mem_skid.sv
// Bench for ex_mem_skid (DATA_W=32, REG_ADDR_W=5): directed steps then random traffic
// against a queue-based reference model; follows EX_MEM_SKID_SKIDBUF_EN like the design.
module tb_ex_mem_skid;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int PW = 2 * DW + AW + 4;
`ifdef EX_MEM_SKID_SKIDBUF_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_i = 1'b0, flush_i = 1'b0, ex_valid_i = 1'b0, mem_ready_i = 1'b0;
  logic          ex_ready_o, mem_valid_o;
  logic [DW-1:0] ex_data1_i = '0, ex_aluResult_i = '0, mem_data1_o, mem_aluResult_o;
  logic [AW-1:0] ex_reg3_i = '0, mem_reg3_o;
  logic          ex_resultOrMem_i = 1'b0, ex_memRead_i = 1'b0, ex_memWrite_i = 1'b0, ex_regWrite_i = 1'b0;
  logic          mem_resultOrMem_o, mem_memRead_o, mem_memWrite_o, mem_regWrite_o;
  logic [1:0]    occ_o;

  ex_mem_skid #(.DATA_W(DW), .REG_ADDR_W(AW)) dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
    .ex_valid_i(ex_valid_i), .ex_ready_o(ex_ready_o),
    .ex_data1_i(ex_data1_i), .ex_aluResult_i(ex_aluResult_i), .ex_reg3_i(ex_reg3_i),
    .ex_resultOrMem_i(ex_resultOrMem_i), .ex_memRead_i(ex_memRead_i),
    .ex_memWrite_i(ex_memWrite_i), .ex_regWrite_i(ex_regWrite_i),
    .mem_valid_o(mem_valid_o), .mem_ready_i(mem_ready_i),
    .mem_data1_o(mem_data1_o), .mem_aluResult_o(mem_aluResult_o), .mem_reg3_o(mem_reg3_o),
    .mem_resultOrMem_o(mem_resultOrMem_o), .mem_memRead_o(mem_memRead_o),
    .mem_memWrite_o(mem_memWrite_o), .mem_regWrite_o(mem_regWrite_o),
    .occ_o(occ_o)
  );

  // Clock
  always #5 clk = ~clk;

  // Scoreboard: entries held by the block, oldest first, plus the last entry shown.
  logic [PW-1:0] exp_q[$];
  logic [PW-1:0] last_head = '0;
  bit            model_known = 1'b0;
  int            n_cmp = 0;
  int            n_err = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [PW-1:0] mk(input logic [DW-1:0] alu, input logic [AW-1:0] r,
                                       input logic [3:0] ctrl);
    return {~alu, alu, r, ctrl};
  endfunction

  function automatic logic [PW-1:0] rand_entry();
    logic [DW-1:0] d1, alu;
    d1  = $urandom;
    alu = $urandom;
    return {d1, alu, 5'($urandom_range(0, 31)), 4'($urandom_range(0, 15))};
  endfunction

  // Driver: apply one cycle of inputs, check ready before the edge, advance the model, check outputs.
  task automatic step(input string tag, input logic v, input logic [PW-1:0] e,
                      input logic mrdy, input logic fl, input logic rs);
    logic          exp_rdy, in_f, out_f;
    logic [PW-1:0] exp_out, obs;
    ex_valid_i       = v;
    {ex_data1_i, ex_aluResult_i, ex_reg3_i} = e[PW-1:4];
    {ex_resultOrMem_i, ex_memRead_i, ex_memWrite_i, ex_regWrite_i} = e[3:0];
    mem_ready_i      = mrdy;
    flush_i          = fl;
    rst_i            = rs;
    #2;
    exp_rdy = SKID ? (exp_q.size() < 2) : (exp_q.size() == 0 || mrdy);
    if (model_known && !rs) chk({tag, " ready"}, 128'(ex_ready_o), 128'(exp_rdy));
    in_f  = v & exp_rdy;
    out_f = (exp_q.size() > 0) & mrdy;
    @(posedge clk);
    if (rs) begin
      exp_q.delete();
      last_head   = '0;
      model_known = 1'b1;
    end else if (fl) begin
      exp_q.delete();
    end else begin
      if (out_f) void'(exp_q.pop_front());
      if (in_f) exp_q.push_back(e);
    end
    if (exp_q.size() > 0) last_head = exp_q[0];
    #1;
    exp_out = last_head;
    if (exp_q.size() == 0) exp_out[2:0] = 3'b000;
    obs = {mem_data1_o, mem_aluResult_o, mem_reg3_o,
           mem_resultOrMem_o, mem_memRead_o, mem_memWrite_o, mem_regWrite_o};
    chk({tag, " valid"}, 128'(mem_valid_o), 128'(exp_q.size() > 0));
    chk({tag, " payload"}, 128'(obs), 128'(exp_out));
    chk({tag, " occ"}, 128'(occ_o), 128'(exp_q.size()));
  endtask

  initial begin
    // Reset with random inputs on the pins
    for (int i = 0; i < 2; i++)
      step("reset", 1'($urandom), rand_entry(), 1'($urandom), 1'($urandom), 1'b1);
    chk("reset ready", 128'(ex_ready_o), 128'(1));
    chk("reset alu", 128'(mem_aluResult_o), 128'(0));

    // Streaming 1..8 at full rate
    for (int i = 1; i <= 8; i++) begin
      step("stream", 1'b1, mk(DW'(i), AW'(i), 4'b0000), 1'b1, 1'b0, 1'b0);
      chk("stream valid_run", 128'(mem_valid_o), 128'(1));
      chk("stream order", 128'(mem_aluResult_o), 128'(i));
    end
    step("stream_end", 1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("stream drained", 128'(mem_valid_o), 128'(0));

    // Backpressure
    step("bp", 1'b1, mk(32'h10, 5'd1, 4'b0000), 1'b1, 1'b0, 1'b0);
    step("bp", 1'b1, mk(32'h11, 5'd2, 4'b0000), 1'b0, 1'b0, 1'b0);
    if (SKID) begin
      chk("bp skid occ", 128'(occ_o), 128'(2));
      chk("bp skid ready", 128'(ex_ready_o), 128'(0));
      for (int i = 0; i < 2; i++) begin
        step("bp hold", 1'b1, mk(32'h12, 5'd3, 4'b0000), 1'b0, 1'b0, 1'b0);
        chk("bp hold alu", 128'(mem_aluResult_o), 128'(32'h10));
      end
      step("bp rel", 1'b1, mk(32'h12, 5'd3, 4'b0000), 1'b1, 1'b0, 1'b0);
      chk("bp order1", 128'(mem_aluResult_o), 128'(32'h11));
      step("bp rel", 1'b1, mk(32'h12, 5'd3, 4'b0000), 1'b1, 1'b0, 1'b0);
      chk("bp order2", 128'(mem_aluResult_o), 128'(32'h12));
    end else begin
      chk("bp hold alu", 128'(mem_aluResult_o), 128'(32'h10));
      step("bp rel", 1'b1, mk(32'h11, 5'd2, 4'b0000), 1'b1, 1'b0, 1'b0);
      chk("bp order1", 128'(mem_aluResult_o), 128'(32'h11));
    end
    step("bp drain", 1'b0, '0, 1'b1, 1'b0, 1'b0);

    // Flush with a same-cycle offer that must be dropped
    step("fl fill", 1'b1, mk(32'hA0, 5'd4, 4'b0000), 1'b1, 1'b0, 1'b0);
    if (SKID) begin
      step("fl fill", 1'b1, mk(32'hA1, 5'd5, 4'b0000), 1'b0, 1'b0, 1'b0);
      chk("fl occ2", 128'(occ_o), 128'(2));
    end
    step("flush", 1'b1, mk(32'hAA, 5'd6, 4'b0111), 1'b0, 1'b1, 1'b0);
    chk("flush ready", 128'(ex_ready_o), 128'(1));
    for (int i = 0; i < 3; i++) begin
      step("post_flush", 1'b0, '0, 1'b1, 1'b0, 1'b0);
      chk("no AA", 128'(mem_aluResult_o == 32'hAA), 128'(0));
    end

    // Control gating on drain
    step("gate", 1'b1, mk(32'h55, 5'd7, 4'b0011), 1'b0, 1'b0, 1'b0);
    chk("gate memWrite on", 128'(mem_memWrite_o), 128'(1));
    chk("gate regWrite on", 128'(mem_regWrite_o), 128'(1));
    step("gate", 1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("gate memWrite off", 128'(mem_memWrite_o), 128'(0));
    chk("gate regWrite off", 128'(mem_regWrite_o), 128'(0));

    // Wide pass-through while full and draining
    step("wide fill", 1'b1, mk(32'h1234, 5'd1, 4'b0000), 1'b0, 1'b0, 1'b0);
    step("wide", 1'b1, mk(32'hDEADBEEF, 5'd31, 4'b1101), 1'b1, 1'b0, 1'b0);
    chk("wide alu", 128'(mem_aluResult_o), 128'(32'hDEADBEEF));
    chk("wide reg3", 128'(mem_reg3_o), 128'(31));
    step("wide drain", 1'b0, '0, 1'b1, 1'b0, 1'b0);

    // Random traffic with occasional flush and reset
    for (int i = 0; i < 400; i++)
      step("rand", 1'($urandom_range(0, 3) != 0), rand_entry(), 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 24) == 0), 1'($urandom_range(0, 59) == 0));

    // Reset mid-operation
    step("mid fill", 1'b1, rand_entry(), 1'b0, 1'b0, 1'b0);
    step("mid rst", 1'b1, rand_entry(), 1'b1, 1'b0, 1'b1);
    step("mid after", 1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("mid no pulse", 128'(mem_valid_o), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
